ddr_frame_reader: RTL and testbench
===================================

DDR_FRAME_READER -- requirements
Module: ddr_frame_reader

Interface
REQ-001 Parameter ADDR_W, default 28, byte address width of memory port.
REQ-002 Parameter BURST_LEN, default 16, 32-bit words per read burst, power of two.
REQ-003 Parameter FRAME_WORDS, default 307200 (640x480), words per frame, multiple of BURST_LEN.
REQ-004 Parameter FIFO_DEPTH, default 64, pixel buffer depth, power of two, >= 2*BURST_LEN.
REQ-005 clk_i  in  1  single clock for all logic; one clock, reset asynchronous and active-high.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 start_i  in  1  one-cycle pulse; begins frame fetch when idle, ignored otherwise.
REQ-008 base_addr_i  in  ADDR_W  frame base byte address, sampled on accepted start_i.
REQ-009 rd_req_o  out  1  burst read request, held until rd_ack_i.
REQ-010 rd_addr_o  out  ADDR_W  burst start byte address, stable while rd_req_o high.
REQ-011 rd_ack_i  in  1  memory accepts request in the cycle both rd_req_o and rd_ack_i are high.
REQ-012 rd_data_i  in  32  read data word, [23:0] = RGB888, [31:24] ignored.
REQ-013 rd_valid_i  in  1  rd_data_i valid; exactly BURST_LEN beats per accepted request, no backpressure.
REQ-014 pix_data_o  out  24  pixel RGB888; pix_valid_o  out  1; pix_ready_i  in  1; transfer when both high.
REQ-015 pix_sof_o  out  1  high with pix_valid_o on the first pixel of each frame.
REQ-016 busy_o  out  1  high from accepted start_i until last pixel of frame transferred.

Function
REQ-017 FSM states IDLE, REQ, DATA, DRAIN; reset state IDLE.
REQ-018 IDLE: on start_i latch base_addr_i, clear word/burst counters, go REQ next cycle.
REQ-019 REQ: assert rd_req_o only when FIFO free entries >= BURST_LEN; on rd_ack_i go DATA.
REQ-020 At most one burst outstanding; no new request before all BURST_LEN beats of current burst received.
REQ-021 rd_addr_o = base + burst_idx*BURST_LEN*4, ADDR_W-bit modulo arithmetic, wrap-around silent.
REQ-022 DATA: each rd_valid_i writes rd_data_i[23:0] into FIFO; after beat BURST_LEN go REQ, or DRAIN if FRAME_WORDS words received.
REQ-023 DRAIN: wait FIFO empty, then IDLE (or REQ per REQ-031); busy_o falls the cycle after last pixel transfer.
REQ-024 pix_valid_o = FIFO not empty; pix_data_o = FIFO head, zero-latency (first-word-fall-through).
REQ-025 pix_data_o and pix_valid_o stable while pix_valid_o high and pix_ready_i low.
REQ-026 Simultaneous FIFO write and read in one cycle keeps occupancy unchanged; flow control guarantees no overflow.
REQ-027 pix_sof_o set on the word at frame word index 0, tracked by a per-FIFO-entry flag bit.
REQ-028 start_i while busy_o high has no effect; rd_valid_i outside DATA is dropped.

Reset
REQ-029 rst_i asserted: FSM to IDLE, FIFO emptied, counters zero, all outputs 0 asynchronously.
REQ-030 Reset mid-burst discards outstanding beats; memory side must tolerate abandoned bursts.

Configuration
REQ-031 Macro FRAME_READER_LOOP_EN defined: after last request of a frame FSM goes REQ with burst_idx 0 and same base, continuous refetch, busy_o stays high until reset; undefined: single frame per start_i, then IDLE.

Structure
REQ-032 Package hdmi_pkg holds the FSM state typedef, pixel_t (24-bit RGB) and BYTES_PER_WORD=4.
REQ-033 One sub-module pix_fifo: synchronous FWFT FIFO, width 25 (pixel+sof), depth FIFO_DEPTH, outputs count.

Verification
REQ-034 BURST_LEN=4, FRAME_WORDS=16, base 0x100, memory returns addr as data -> requests at 0x100,0x110,0x120,0x130; pixels 0x100..0x13C in order; sof on first only.
REQ-035 pix_ready_i held low -> after FIFO_DEPTH words buffered rd_req_o stays low; releasing ready resumes requests, no data lost.
REQ-036 rd_ack_i delayed 7 cycles -> rd_req_o and rd_addr_o stable throughout, single burst accepted.
REQ-037 rst_i asserted during beat 2 of burst 1 -> all outputs 0 same cycle, busy_o 0, next start_i fetches from burst 0.
REQ-038 base 0xFFFFFF0, ADDR_W=28 -> second burst address wraps to 0x0000000.
REQ-039 With FRAME_READER_LOOP_EN, two frames -> sof asserted at pixel 0 and pixel 16, busy_o never falls.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types for the DDR frame reader: FSM state, pixel word, FIFO entry.
package hdmi_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic   sof;
    pixel_t pix;
  } fifo_word_t;

endpackage

// File: rtl/ddr_frame_reader_pix_fifo.sv
// pix_fifo: first-word-fall-through pixel buffer, pixel plus start-of-frame flag.
module pix_fifo
  import hdmi_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  fifo_word_t wr_data_i,
  input  logic       rd_en_i,
  output fifo_word_t rd_data_o,
  output logic       empty_o,
  output logic [AW:0] count_o
);

  fifo_word_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign do_wr = wr_en_i && (count_q != (AW+1)'(DEPTH));
  assign do_rd = rd_en_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/ddr_frame_reader.sv
// Burst reader streaming a frame from DDR into a pixel FIFO.
// FRAME_READER_LOOP_EN: refetch the frame continuously instead of stopping.
module ddr_frame_reader
  import hdmi_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_ack_i,
  input  logic [31:0]       rd_data_i,
  input  logic              rd_valid_i,
  output logic [23:0]       pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_sof_o,
  output logic              busy_o
);

  localparam int NBURST = FRAME_WORDS / BURST_LEN;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int IW = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SH = $clog2(BURST_LEN * BYTES_PER_WORD);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IW-1:0]     burst_q, burst_d;
  logic [BW-1:0]     beat_q, beat_d;

  fifo_word_t        wr_word, head;
  logic              wr_en, rd_en, empty;
  logic [CW-1:0]     count;
  logic              last_beat, last_burst, can_req, drained;
  logic              unused_hi;

  assign unused_hi  = ^rd_data_i[31:24];
  assign last_beat  = (beat_q == BW'(BURST_LEN - 1));
  assign last_burst = (burst_q == IW'(NBURST - 1));
  // Only request when a whole burst fits, so beats never need backpressure.
  assign can_req    = (CW'(FIFO_DEPTH) - count) >= CW'(BURST_LEN);
  assign wr_en      = (state_q == ST_DATA) && rd_valid_i;
  assign rd_en      = !empty && pix_ready_i;
  assign drained    = empty || ((count == CW'(1)) && rd_en);

  always_comb begin
    wr_word.sof = (burst_q == '0) && (beat_q == '0);
    wr_word.pix = rd_data_i[23:0];
  end

  pix_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (wr_en),
    .wr_data_i(wr_word),
    .rd_en_i  (rd_en),
    .rd_data_o(head),
    .empty_o  (empty),
    .count_o  (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          burst_d = '0;
          beat_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (can_req && rd_ack_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (rd_valid_i) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              burst_d = '0;
`ifdef FRAME_READER_LOOP_EN
              state_d = ST_REQ;
`else
              state_d = ST_DRAIN;
`endif
            end else begin
              burst_d = burst_q + 1'b1;
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (drained) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_req_o    = (state_q == ST_REQ) && can_req;
    rd_addr_o   = base_q + (ADDR_W'(burst_q) << SH);
    busy_o      = (state_q != ST_IDLE);
    pix_valid_o = !empty;
    pix_data_o  = empty ? '0 : head.pix;
    pix_sof_o   = !empty && head.sof;
  end

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Directed bench for ddr_frame_reader with a burst memory responder.
module tb_ddr_frame_reader;

  localparam int AW = 28;
  localparam int BL = 4;
  localparam int FW = 16;
  localparam int FD = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic          rd_req_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_ack_i = 1'b0;
  logic [31:0]   rd_data_i = '0;
  logic          rd_valid_i = 1'b0;
  logic [23:0]   pix_data_o;
  logic          pix_valid_o;
  logic          pix_ready_i = 1'b0;
  logic          pix_sof_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  ddr_frame_reader #(
    .ADDR_W     (AW),
    .BURST_LEN  (BL),
    .FRAME_WORDS(FW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .rd_req_o   (rd_req_o),
    .rd_addr_o  (rd_addr_o),
    .rd_ack_i   (rd_ack_i),
    .rd_data_i  (rd_data_i),
    .rd_valid_i (rd_valid_i),
    .pix_data_o (pix_data_o),
    .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i),
    .pix_sof_o  (pix_sof_o),
    .busy_o     (busy_o)
  );

  int checks = 0;
  int errors = 0;

  int            ack_dly = 0;
  int            wcnt = 0;
  int            left = 0;
  int            beat_no = 0;
  logic          hs_pend = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic [AW-1:0] cur = '0;
  logic [23:0]   prev_pix = '0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] req_log [$];
  logic [24:0]   pix_log [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: returns the byte address as data, BL beats per accepted request.
  always @(negedge clk_i) begin
    if (rst_i) begin
      rd_ack_i   = 1'b0;
      rd_valid_i = 1'b0;
      rd_data_i  = '0;
      left       = 0;
      wcnt       = 0;
      hs_pend    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (hs_pend) begin
        left = BL;
        cur  = hs_addr;
      end
      rd_valid_i = 1'b0;
      if (left > 0) begin
        rd_valid_i = 1'b1;
        rd_data_i  = 32'(cur);
        beat_no    = BL - left;
        cur        = cur + AW'(4);
        left--;
      end
      rd_ack_i = 1'b0;
      hs_pend  = 1'b0;
      if (rd_req_o) begin
        if (wcnt >= ack_dly) begin
          rd_ack_i = 1'b1;
          hs_pend  = 1'b1;
          hs_addr  = rd_addr_o;
          req_log.push_back(rd_addr_o);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (pix_valid_o && pix_ready_i)
        pix_log.push_back({pix_sof_o, pix_data_o});
      if (prev_stall) begin
        chk("stall_valid", 32'(pix_valid_o), 32'd1);
        chk("stall_data", 32'(pix_data_o), 32'(prev_pix));
      end
      prev_stall = pix_valid_o && !pix_ready_i;
      prev_pix   = pix_data_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] a);
    base_addr_i = a;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy_o && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic clr();
    req_log.delete();
    pix_log.delete();
  endtask

  function automatic logic [AW-1:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 'x;
  endfunction

  function automatic logic [24:0] pix_at(input int i);
    return (i < pix_log.size()) ? pix_log[i] : 'x;
  endfunction

  task automatic chk_frame(input logic [AW-1:0] b);
    logic [24:0]   e;
    logic [AW-1:0] a;
    chk("req_count", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      a = b + AW'(16 * i);
      chk("req_addr", 32'(req_at(i)), 32'(a));
    end
    chk("pix_count", 32'(pix_log.size()), 32'(FW));
    for (int i = 0; i < FW; i++) begin
      e = pix_at(i);
      a = b + AW'(4 * i);
      chk("pix_data", 32'(e[23:0]), 32'(a[23:0]));
      chk("pix_sof", 32'(e[24]), (i == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(rd_req_o), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr_o), 32'd0);
    chk({tag, "_valid"}, 32'(pix_valid_o), 32'd0);
    chk({tag, "_data"}, 32'(pix_data_o), 32'd0);
    chk({tag, "_sof"}, 32'(pix_sof_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [24:0] e;
    int n;

    repeat (2) tick();
    chk_zero("reset");
    rst_i = 1'b0;
    tick();

    // Reset in the middle of beat 2 of burst 1, then restart from burst 0.
    pix_ready_i = 1'b1;
    clr();
    start(28'h400);
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!(req_log.size() == 2 && rd_valid_i && beat_no == 2) && n < 200);
    chk("mid_burst_reached", 32'(n < 200), 32'd1);
    rst_i = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    clr();

`ifdef FRAME_READER_LOOP_EN
    start(28'h100);
    n = 0;
    while (pix_log.size() < 20 && n < 300) begin
      chk("loop_busy", 32'(busy_o), 32'd1);
      tick();
      n++;
    end
    chk("loop_reached", 32'(pix_log.size() >= 20), 32'd1);
    e = pix_at(0);
    chk("loop_sof0", 32'(e[24]), 32'd1);
    chk("loop_pix0", 32'(e[23:0]), 32'h100);
    e = pix_at(1);
    chk("loop_sof1", 32'(e[24]), 32'd0);
    e = pix_at(15);
    chk("loop_pix15", 32'(e[23:0]), 32'h13C);
    chk("loop_sof15", 32'(e[24]), 32'd0);
    e = pix_at(16);
    chk("loop_sof16", 32'(e[24]), 32'd1);
    chk("loop_pix16", 32'(e[23:0]), 32'h100);
    chk("loop_req4", 32'(req_at(4)), 32'h100);
`else
    start(28'h400);
    wait_idle(200, "restart_idle");
    chk_frame(28'h400);

    // Basic frame; a second start while busy must be ignored.
    clr();
    start(28'h100);
    chk("busy_rise", 32'(busy_o), 32'd1);
    tick();
    start(28'h500);
    wait_idle(200, "frame1_idle");
    chk_frame(28'h100);

    // Consumer stalled: fetching stops once the buffer is full.
    clr();
    pix_ready_i = 1'b0;
    start(28'h200);
    repeat (60) tick();
    chk("bp_reqs", 32'(req_log.size()), 32'd2);
    chk("bp_req_low", 32'(rd_req_o), 32'd0);
    chk("bp_busy", 32'(busy_o), 32'd1);
    chk("bp_head", 32'(pix_data_o), 32'h200);
    chk("bp_sof", 32'(pix_sof_o), 32'd1);
    pix_ready_i = 1'b1;
    wait_idle(200, "bp_idle");
    chk_frame(28'h200);

    // Slow acknowledge: request and address hold until accepted.
    clr();
    ack_dly = 7;
    start(28'h300);
    chk("dly_req0", 32'(rd_req_o), 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("dly_req", 32'(rd_req_o), 32'd1);
      chk("dly_addr", 32'(rd_addr_o), 32'h300);
      chk("dly_noacc", 32'(req_log.size()), 32'd0);
    end
    wait_idle(400, "dly_idle");
    chk_frame(28'h300);
    ack_dly = 0;

    // Address arithmetic wraps at the top of the address space.
    clr();
    start(28'hFFFFFF0);
    wait_idle(200, "wrap_idle");
    chk("wrap_a0", 32'(req_at(0)), 32'hFFFFFF0);
    chk("wrap_a1", 32'(req_at(1)), 32'h0000000);
    chk("wrap_a2", 32'(req_at(2)), 32'h0000010);
    chk("wrap_a3", 32'(req_at(3)), 32'h0000020);
    e = pix_at(0);
    chk("wrap_p0", 32'(e[23:0]), 32'hFFFFF0);
    chk("wrap_sof", 32'(e[24]), 32'd1);
    e = pix_at(4);
    chk("wrap_p4", 32'(e[23:0]), 32'h000000);
    e = pix_at(15);
    chk("wrap_p15", 32'(e[23:0]), 32'h00002C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
